tmds_channel_decoder: RTL and testbench

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder.sv | 172 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS single-channel receiver: finds the 10-bit symbol boundary by hunting for
// runs of control tokens, then decodes control and video symbols at that offset.
module tmds_channel_decoder #(
  parameter int CTRL_RUN     = 12,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [9:0] tmds_in,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  localparam int RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int DWELL_W = $clog2(SEARCH_DWELL);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT);

  typedef enum logic {SEARCH, LOCKED} state_e;

  // Returns {hit, C1, C0}.
  function automatic logic [2:0] token_lookup(input logic [9:0] s);
    logic [2:0] r;
    case (s)
      10'h354: r = 3'b100;
      10'h0AB: r = 3'b101;
      10'h154: r = 3'b110;
      10'h2AB: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] video_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  logic [9:0]         cur_q, cur_d, prev_q, prev_d;
  state_e             state_q, state_d;
  logic [3:0]         offset_q, offset_d, offset_inc;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic               locked_q, locked_d, lock_lost_q, lock_lost_d;
  logic               de_q, de_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [7:0]         data_q, data_d;
  logic [19:0]        window;
  logic [9:0]         sym;
  logic [2:0]         tok;
  logic               run_full;

  always_comb begin
    cur_d       = tmds_in;
    prev_d      = cur_q;
    state_d     = state_q;
    offset_d    = offset_q;
    dwell_d     = dwell_q;
    timeout_d   = timeout_q;
    lock_lost_d = 1'b0;
    de_d        = 1'b0;
    ctrl_d      = 2'b00;
    data_d      = 8'h00;

    // Stage 1 boundary: symbol selection from the two most recent words
    window     = {cur_q, prev_q};
    sym        = 10'(window >> offset_q);
    tok        = token_lookup(sym);
    offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    if (!tok[2]) begin
      run_d = '0;
    end else if (run_q == RUN_W'(CTRL_RUN)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 1'b1;
    end
    run_full = (run_d == RUN_W'(CTRL_RUN));

    unique case (state_q)
      SEARCH: begin
        // A completed run beats dwell expiry so the offset that just matched is kept.
        if (run_full) begin
          state_d   = LOCKED;
          dwell_d   = '0;
          timeout_d = '0;
        end else if (dwell_q == DWELL_W'(SEARCH_DWELL - 1)) begin
          offset_d = offset_inc;
          dwell_d  = '0;
          run_d    = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      LOCKED: begin
        if (run_full) begin
          timeout_d = '0;
        end else if (timeout_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d     = SEARCH;
          offset_d    = offset_inc;
          run_d       = '0;
          dwell_d     = '0;
          timeout_d   = '0;
          lock_lost_d = 1'b1;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
    endcase

    locked_d = (state_d == LOCKED);
    if (state_d == LOCKED) begin
      if (tok[2]) begin
        ctrl_d = tok[1:0];
      end else begin
        de_d   = 1'b1;
        ctrl_d = ctrl_q;
        data_d = video_decode(sym);
      end
    end
  end

  // Stage 2 boundary: registered control state and decoded outputs
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      cur_q       <= '0;
      prev_q      <= '0;
      state_q     <= SEARCH;
      offset_q    <= '0;
      run_q       <= '0;
      dwell_q     <= '0;
      timeout_q   <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      de_q        <= 1'b0;
      ctrl_q      <= 2'b00;
      data_q      <= 8'h00;
    end else begin
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      offset_q    <= offset_d;
      run_q       <= run_d;
      dwell_q     <= dwell_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      de_q        <= de_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
    end
  end

  assign locked    = locked_q;
  assign offset    = offset_q;
  assign lock_lost = lock_lost_q;
  assign de        = de_q;
  assign ctrl      = ctrl_q;
  assign data      = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: scoreboard of expected {locked,de,ctrl,data}
// per driven word, plus directed checks on search stepping and lock loss.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN     = 12;
  localparam int SEARCH_DWELL = 64;
  localparam int LOCK_TIMEOUT = 256;

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic [9:0] tmds_in   = '0;
  logic       locked, lock_lost, de;
  logic [3:0] offset;
  logic [1:0] ctrl;
  logic [7:0] data;

  tmds_channel_decoder #(
    .CTRL_RUN    (CTRL_RUN),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .tmds_in  (tmds_in),
    .locked   (locked),
    .offset   (offset),
    .lock_lost(lock_lost),
    .de       (de),
    .ctrl     (ctrl),
    .data     (data)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int         due;
    logic [11:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ev(input logic lk, input logic d, input logic [1:0] c,
                                     input logic [7:0] v);
    return {lk, d, c, v};
  endfunction

  task automatic step(input logic [9:0] w);
    sb_t e;
    tmds_in = w;
    @(posedge clk_pixel);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check_eq("sb_out", {locked, de, ctrl, data}, e.exp);
    end
  endtask

  // Word sampled at edge cyc+1 shows up on the outputs after edge cyc+3.
  task automatic step_exp(input logic [9:0] w, input logic [11:0] exp);
    sb_t e;
    e.due = cyc + 3;
    e.exp = exp;
    sb_q.push_back(e);
    step(w);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_offset"}, offset, 0);
    check_eq({tag, "_lost"}, lock_lost, 0);
    check_eq({tag, "_de"}, de, 0);
    check_eq({tag, "_ctrl"}, ctrl, 0);
    check_eq({tag, "_data"}, data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int          rel;
    int          last_chg;
    int          steps;
    int          j;
    logic [3:0]  last_off;
    logic [9:0]  w_first, w_rot;
    logic [9:0]  tok354;

    // Reset with random input
    rst_n = 1'b0;
    repeat (2) step(10'($urandom_range(0, 1023)));
    check_all_zero("rst");
    rst_n = 1'b1;

    // Aligned lock, timed so the 12th token completes on the dwell-expiry edge
    for (int k = 0; k < 50; k++) step_exp(10'h10F, ev(0, 0, 2'b00, 8'h00));
    for (int k = 50; k < 61; k++) step_exp(10'h354, ev(0, 0, 2'b00, 8'h00));
    step_exp(10'h354, ev(1, 0, 2'b00, 8'h00));
    step_exp(10'h10F, ev(1, 1, 2'b00, 8'h11));
    step_exp(10'h2F0, ev(1, 1, 2'b00, 8'hEF));
    step_exp(10'h0AB, ev(1, 0, 2'b01, 8'h00));
    step_exp(10'h2AB, ev(1, 0, 2'b11, 8'h00));
    step_exp(10'h10F, ev(1, 1, 2'b11, 8'h11));
    step_exp(10'h154, ev(1, 0, 2'b10, 8'h00));
    step_exp(10'h10F, ev(1, 1, 2'b10, 8'h11));
    step(10'h10F);
    step(10'h10F);
    check_eq("sb_drain", sb_q.size(), 0);
    check_eq("lock_wins_off", offset, 0);
    check_eq("lock_wins_lk", locked, 1);
    check_eq("pre_rst_de", de, 1);

    // Reset while locked with de=1
    rst_n = 1'b0;
    step(10'($urandom_range(0, 1023)));
    sb_q.delete();
    check_all_zero("midrst");
    step(10'($urandom_range(0, 1023)));
    rst_n = 1'b1;

    // Token stream delayed by 3 bits on the wire
    tok354   = 10'h354;
    w_first  = 10'((tok354 << 3) & 10'h3FF);
    w_rot    = 10'(((tok354 << 3) | (tok354 >> 7)) & 10'h3FF);
    rel      = cyc;
    last_chg = cyc;
    last_off = 4'd0;
    steps    = 0;
    for (int i = 0; i < 400 && !locked; i++) begin
      step((i == 0) ? w_first : w_rot);
      if (i == 0) check_eq("srch_state", locked, 0);
      if (offset != last_off) begin
        check_eq("off_step", offset, (last_off == 4'd9) ? 4'd0 : last_off + 4'd1);
        check_eq("off_dwell", cyc - last_chg, SEARCH_DWELL);
        last_off = offset;
        last_chg = cyc;
        steps++;
      end
    end
    check_eq("mis_locked", locked, 1);
    check_eq("mis_offset", offset, 3);
    check_eq("mis_steps", steps, 3);
    check_eq("mis_lock_cyc", cyc - rel, 3 * SEARCH_DWELL + CTRL_RUN);

    // Lock loss: only video words from here on
    j = 0;
    while (!lock_lost && j < 400) begin
      step(10'h10F);
      j++;
    end
    check_eq("lost_cyc", j, LOCK_TIMEOUT + 1);
    check_eq("lost_pulse", lock_lost, 1);
    check_eq("lost_locked", locked, 0);
    check_eq("lost_offset", offset, 4);
    check_eq("lost_de", de, 0);
    step(10'h10F);
    check_eq("lost_once", lock_lost, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
